// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder that adds LSB first through one full-adder cell.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output Ovf.
module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;
endmodule

module serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             In_valid,
  output logic             In_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-2:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             ha0_s, ha0_c, bit_s, ha1_c, carry_nxt;
  logic [WIDTH-1:0] sum_cat;

  half_adder u_ha0 (.a_i(a_q[0]), .b_i(b_q[0]),  .s_o(ha0_s), .c_o(ha0_c));
  half_adder u_ha1 (.a_i(ha0_s),  .b_i(carry_q), .s_o(bit_s), .c_o(ha1_c));
  assign carry_nxt = ha0_c | ha1_c;

  // The final bit never needs storing: it goes straight into the result register.
  assign sum_cat = {bit_s, sum_sh_q};

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (In_valid && in_ready_q) begin
          a_d     = A;
          b_d     = B;
          carry_d = Cin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        sum_sh_d = sum_cat[WIDTH-1:1];
        carry_d  = carry_nxt;
        if (cnt_q == LAST) begin
          sum_d   = sum_cat;
          cout_d  = carry_nxt;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = carry_q ^ carry_nxt;
`endif
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (Out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_sh_q    <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_sh_q    <= sum_sh_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign In_ready  = in_ready_q;
  assign Out_valid = out_valid_q;
  assign Sum       = sum_q;
  assign Cout      = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign Ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder (WIDTH=16) against hand values and an arithmetic model.
module tb_serial_adder;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        In_valid;
  logic        In_ready;
  logic [15:0] A, B;
  logic        Cin;
  logic        Out_valid;
  logic        Out_ready;
  logic [15:0] Sum;
  logic        Cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic        Ovf;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  serial_adder #(.WIDTH(16)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .In_valid(In_valid), .In_ready(In_ready),
    .A(A), .B(B), .Cin(Cin),
    .Out_valid(Out_valid), .Out_ready(Out_ready),
    .Sum(Sum), .Cout(Cout)
`ifdef SERIAL_ADDER_OVF_EN
    , .Ovf(Ovf)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_out(input string tag);
    int w;
    w = 0;
    while (!Out_valid && w < 100) begin tick(); w++; end
    if (!Out_valid) check({tag, "_vld_timeout"}, Out_valid, 1);
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic [15:0] es, input logic ec,
                        input logic eo, input bit chk_lat);
    int w, lat;
    w = 0;
    while (!In_ready && w < 100) begin tick(); w++; end
    if (!In_ready) check({tag, "_rdy_timeout"}, In_ready, 1);
    A = a; B = b; Cin = cin; In_valid = 1'b1; Out_ready = 1'b1;
    tick();
    In_valid = 1'b0;
    lat = 0;
    while (!Out_valid && lat < 100) begin tick(); lat++; end
    if (chk_lat) check({tag, "_lat"}, lat, 16);
    else if (!Out_valid) check({tag, "_vld_timeout"}, Out_valid, 1);
    check({tag, "_sum"}, Sum, es);
    check({tag, "_cout"}, Cout, ec);
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, "_ovf"}, Ovf, eo);
`else
    if (eo === 1'bx) check({tag, "_eo"}, eo, 0);
`endif
    tick();
  endtask

  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic cin);
    logic [16:0] r;
    logic        ov;
    r  = {1'b0, a} + {1'b0, b} + {16'b0, cin};
    ov = (a[15] == b[15]) && (r[15] != a[15]);
    return {ov, r};
  endfunction

  logic [15:0] va[3];
  logic [15:0] vb[3];
  logic        vc[3];
  int          acc_t[3];
  int          n_acc, n_done;
  bit          took;
  logic [17:0] m;

  initial begin
    Reset_n = 1'b0; In_valid = 1'b0; Out_ready = 1'b0;
    A = '0; B = '0; Cin = 1'b0;
    #1;
    check("rst_in_ready", In_ready, 0);
    check("rst_out_valid", Out_valid, 0);
    check("rst_sum", Sum, 0);
    check("rst_cout", Cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf", Ovf, 0);
`endif
    tick(); tick();
    Reset_n = 1'b1;
    check("rel_in_ready_low", In_ready, 0);
    tick();
    check("rel_in_ready", In_ready, 1);

    run_op("t1234", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1);
    check("post_hs_in_ready", In_ready, 1);
    check("post_hs_out_valid", Out_valid, 0);
    check("post_hs_sum_held", Sum, 16'h5555);
    run_op("tffff1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1);
    run_op("tffffc", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1);

    // Backpressure with In_valid held high and different operands pending.
    A = 16'h1111; B = 16'h2222; Cin = 1'b0; In_valid = 1'b1; Out_ready = 1'b0;
    tick();
    A = 16'h0101; B = 16'h0202; Cin = 1'b1;
    check("bp_busy_in_ready", In_ready, 0);
    wait_out("bp");
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", Out_valid, 1);
      check("bp_in_ready", In_ready, 0);
      check("bp_sum", Sum, 16'h3333);
      check("bp_cout", Cout, 0);
      tick();
    end
    Out_ready = 1'b1;
    tick();
    check("bp_hs_in_ready", In_ready, 1);
    check("bp_hs_out_valid", Out_valid, 0);
    tick();
    In_valid = 1'b0;
    check("bp_next_busy", In_ready, 0);
    wait_out("bp2");
    check("bp2_sum", Sum, 16'h0304);
    check("bp2_cout", Cout, 0);
    tick();

    // Reset in the middle of an operation.
    A = 16'h00F0; B = 16'h0F00; Cin = 1'b0; In_valid = 1'b1;
    tick();
    In_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    Reset_n = 1'b0;
    #1;
    check("mid_rst_sum", Sum, 0);
    check("mid_rst_cout", Cout, 0);
    check("mid_rst_out_valid", Out_valid, 0);
    check("mid_rst_in_ready", In_ready, 0);
`ifdef SERIAL_ADDER_OVF_EN
    check("mid_rst_ovf", Ovf, 0);
`endif
    tick();
    Reset_n = 1'b1;
    tick();
    check("mid_rel_in_ready", In_ready, 1);
    run_op("t3p4", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 1);

`ifdef SERIAL_ADDER_OVF_EN
    run_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1);
    run_op("ovf_neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1);
    run_op("ovf_none", 16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0, 1);
`endif

    // Back-to-back with Out_ready tied high.
    va[0] = 16'hA5A5; vb[0] = 16'h5A5A; vc[0] = 1'b1;
    va[1] = 16'h8001; vb[1] = 16'h7FFF; vc[1] = 1'b0;
    va[2] = 16'h0F0F; vb[2] = 16'h00FF; vc[2] = 1'b1;
    n_acc = 0; n_done = 0;
    Out_ready = 1'b1; A = va[0]; B = vb[0]; Cin = vc[0]; In_valid = 1'b1;
    for (int c = 0; c < 200 && n_done < 3; c++) begin
      took = 1'b0;
      if (In_valid && In_ready && n_acc < 3) begin
        acc_t[n_acc] = c; n_acc++; took = 1'b1;
      end
      if (Out_valid && n_done < 3) begin
        m = model(va[n_done], vb[n_done], vc[n_done]);
        check("b2b_sum", Sum, m[15:0]);
        check("b2b_cout", Cout, m[16]);
        n_done++;
      end
      tick();
      if (took) begin
        if (n_acc < 3) begin
          A = va[n_acc]; B = vb[n_acc]; Cin = vc[n_acc];
        end else begin
          In_valid = 1'b0;
        end
      end
    end
    In_valid = 1'b0;
    check("b2b_done", n_done, 3);
    if (n_acc == 3) begin
      check("b2b_gap1", acc_t[1] - acc_t[0], 18);
      check("b2b_gap2", acc_t[2] - acc_t[1], 18);
    end else begin
      check("b2b_accepts", n_acc, 3);
    end

    for (int i = 0; i < 1000; i++) begin
      logic [15:0] ra, rb;
      logic        rc;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      m  = model(ra, rb, rc);
      run_op("rnd", ra, rb, rc, m[15:0], m[16], m[17], 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
